// File: rtl/regfile_access_arbiter.sv
// Two-requester round-robin arbiter that serialises register-bank accesses
// through an IDLE -> ISSUE -> WAIT handshake with a response timeout.
module regfile_access_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int REG_WIDTH  = 16,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [REG_WIDTH-1:0]  req0_wdata,
  output logic                  req0_ack,
  output logic [REG_WIDTH-1:0]  req0_rdata,
  output logic                  req0_error,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [REG_WIDTH-1:0]  req1_wdata,
  output logic                  req1_ack,
  output logic [REG_WIDTH-1:0]  req1_rdata,
  output logic                  req1_error,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [REG_WIDTH-1:0]  rf_wdata,
  output logic                  rf_read,
  output logic                  rf_write,
  input  logic [REG_WIDTH-1:0]  rf_rdata,
  input  logic                  rf_done,
  input  logic                  rf_error,
  output logic [7:0]            err_count
);

  localparam int CW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state_reg, state_next;
  logic           grant_reg;
  logic           last_grant_reg;
  logic           write_reg;
  logic [CW-1:0]  wait_cnt_reg;

  logic           elig0, elig1, any_elig;
  logic           grant_next;
  logic           finish;
  logic           resp_error;
  logic [REG_WIDTH-1:0] resp_rdata;

  // A requester being acked this cycle still has valid high; it must not re-win.
  assign elig0    = req0_valid & ~req0_ack;
  assign elig1    = req1_valid & ~req1_ack;
  assign any_elig = elig0 | elig1;

  always_comb begin
    grant_next = 1'b0;
    if (elig0 && elig1) grant_next = ~last_grant_reg;
    else if (elig1)     grant_next = 1'b1;
  end

  always_comb begin
    state_next = state_reg;
    finish     = 1'b0;
    rf_read    = 1'b0;
    rf_write   = 1'b0;
    resp_error = 1'b1;
    resp_rdata = '0;
    case (state_reg)
      IDLE:  if (any_elig) state_next = ISSUE;
      ISSUE: begin
        rf_read    = ~write_reg;
        rf_write   = write_reg;
        state_next = WAIT;
      end
      WAIT: begin
        if (rf_done || wait_cnt_reg == CW'(TIMEOUT - 1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
        // Timeout path keeps the error=1 / rdata=0 defaults.
        if (rf_done) begin
          resp_error = rf_error;
          resp_rdata = write_reg ? '0 : rf_rdata;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
      write_reg      <= 1'b0;
      wait_cnt_reg   <= '0;
      rf_addr        <= '0;
      rf_wdata       <= '0;
      req0_ack       <= 1'b0;
      req1_ack       <= 1'b0;
      req0_rdata     <= '0;
      req1_rdata     <= '0;
      req0_error     <= 1'b0;
      req1_error     <= 1'b0;
      err_count      <= '0;
    end else begin
      state_reg <= state_next;
      req0_ack  <= 1'b0;
      req1_ack  <= 1'b0;

      if (state_reg == IDLE && any_elig) begin
        grant_reg <= grant_next;
        write_reg <= grant_next ? req1_write : req0_write;
        rf_addr   <= grant_next ? req1_addr  : req0_addr;
        rf_wdata  <= grant_next ? req1_wdata : req0_wdata;
      end

      if (state_reg == WAIT && !finish) wait_cnt_reg <= wait_cnt_reg + 1'b1;
      else                              wait_cnt_reg <= '0;

      if (finish) begin
        last_grant_reg <= grant_reg;
        if (grant_reg) begin
          req1_ack   <= 1'b1;
          req1_rdata <= resp_rdata;
          req1_error <= resp_error;
        end else begin
          req0_ack   <= 1'b1;
          req0_rdata <= resp_rdata;
          req0_error <= resp_error;
        end
        if (resp_error && err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: doc/regfile_access_arbiter.md
REGFILE_ACCESS_ARBITER -- requirements
Module: regfile_access_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, register address width.
REQ-002 The block SHALL have parameter REG_WIDTH, default 16, register data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 4, max WAIT cycles without rf_done.
REQ-004 The block SHALL have port clk, input, 1, system clock, rising-edge active.
REQ-005 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-006 The block SHALL have port reqN_valid (N=0,1), input, 1, access request, held until reqN_ack.
REQ-007 The block SHALL have port reqN_write, input, 1, 1=write, 0=read.
REQ-008 The block SHALL have port reqN_addr, input, ADDR_WIDTH, target register address.
REQ-009 The block SHALL have port reqN_wdata, input, REG_WIDTH, write data.
REQ-010 The block SHALL have port reqN_ack, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port reqN_rdata, output, REG_WIDTH, read result, valid with ack.
REQ-012 The block SHALL have port reqN_error, output, 1, access error, valid with ack.
REQ-013 The block SHALL have ports rf_addr, rf_wdata, outputs, ADDR_WIDTH/REG_WIDTH, to the register bank.
REQ-014 The block SHALL have ports rf_read, rf_write, outputs, 1, register bank strobes.
REQ-015 The block SHALL have ports rf_rdata (REG_WIDTH), rf_done (1) and rf_error (1), inputs, register bank responses.
REQ-016 The block SHALL have port err_count, output, 8, saturating count of errored accesses.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE and WAIT.
REQ-018 In IDLE, when any eligible reqN_valid=1, the FSM SHALL grant one requester, latch its write/addr/wdata, and enter ISSUE next cycle.
REQ-019 A requester whose reqN_ack=1 in the current cycle SHALL be ineligible in that cycle.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; last_grant updates on ack.
REQ-021 In ISSUE, exactly one of rf_read/rf_write SHALL be 1 for exactly one cycle with latched rf_addr/rf_wdata; the FSM then enters WAIT.
REQ-022 rf_read and rf_write SHALL be 0 in all states except ISSUE; rf_addr and rf_wdata SHALL hold the latched values until the next grant.
REQ-023 In WAIT, on rf_done=1 the block SHALL register reqN_ack=1 for the granted requester, reqN_rdata=rf_rdata for reads (0 for writes), reqN_error=rf_error, then return to IDLE.
REQ-024 If rf_done stays 0 for TIMEOUT consecutive WAIT cycles, the block SHALL ack with reqN_error=1 and reqN_rdata=0, then return to IDLE.
REQ-025 Latency SHALL be fixed: valid seen in IDLE at cycle T -> strobe at T+1 -> ack high at T+3 for a 1-cycle-latency register bank.
REQ-026 reqN_rdata and reqN_error SHALL hold their values until the next ack to that requester; reqN_ack SHALL be a single-cycle pulse.
REQ-027 err_count SHALL increment by 1 on each ack with error=1, saturating at 0xFF.
REQ-028 Requests arriving in ISSUE or WAIT SHALL wait; none SHALL be dropped or issued twice.

Reset
REQ-029 While rst_n=0 at a clock edge, state SHALL be IDLE; all acks, strobes, rf_addr, rf_wdata, reqN_rdata, reqN_error and err_count SHALL be 0; last_grant SHALL be 1 so req0 wins first.
REQ-030 Reset in ISSUE or WAIT SHALL abort the access with no ack and no err_count update.

Verification
REQ-031 After reset, req0 read addr 0x12 -> rf_read pulse at T+1, req0_ack at T+3, req0_rdata=0xFFFF, req0_error=0.
REQ-032 req0 and req1 valid in the same cycle (write 0x10 data 0x0003; read 0x14) -> req0 served first, then req1; req1_rdata=0x0002.
REQ-033 req1 write addr 0x05 -> req1_error=1, err_count=1; 300 such errors -> err_count stays 0xFF.
REQ-034 Register bank model holds rf_done=0 -> ack after 4 WAIT cycles with error=1, rdata=0.
REQ-035 rst_n=0 during WAIT -> no ack, strobes 0, next request granted to req0.
